load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit: decodes and faults accesses, drives the
// data SRAM port with a grant/response handshake, and aligns/extends load data.
module load_store_unit #(
  parameter int DM_AW    = 14,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [4:0]       req_rd,
  input  logic             flush,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic [4:0]       rsp_rd,
  output logic             rsp_fault,
  output logic [1:0]       rsp_fault_code,
  output logic             busy,
  output logic             DM_CS,
  output logic             DM_OE,
  output logic [3:0]       DM_WEB,
  output logic [DM_AW-1:0] DM_A,
  output logic [31:0]      DM_DI,
  input  logic [31:0]      DM_DO,
  input  logic             dm_gnt,
  input  logic             dm_rvalid
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

  state_t          state;
  logic            st_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [3:0]      web_q;
  logic [CW-1:0]   cnt;
  logic            drop;

  logic            is_st, illegal, misal, timeout;
  logic [2:0]      f3;
  logic [3:0]      web_n;
  logic [31:0]     di_n, ld_sh, ld_data;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:DM_AW+2];

  assign is_st   = req_op[3];
  assign f3      = req_op[2:0];
  assign illegal = is_st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
  assign misal   = (f3[1:0] == 2'd1 && req_addr[0]) ||
                   (f3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
  assign timeout = (MAX_WAIT > 0) && (cnt == LIMIT);

  // Store lane placement computed at accept so DM_* only ever see registers.
  always_comb begin
    web_n = 4'h0;
    di_n  = req_wdata;
    case (f3[1:0])
      2'd0: begin
        web_n = ~(4'b0001 << req_addr[1:0]);
        di_n  = {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
      end
      2'd1: begin
        web_n = req_addr[1] ? 4'b0011 : 4'b1100;
        di_n  = {16'b0, req_wdata[15:0]} << {req_addr[1], 4'b0000};
      end
      default: ;
    endcase
  end

  // Halfword offsets are even, so a byte-granular shift also aligns halves.
  assign ld_sh = DM_DO >> {off_q, 3'b000};
  always_comb begin
    ld_data = DM_DO;
    case (f3_q)
      3'd0: ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'd1: ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'd4: ld_data = {24'b0, ld_sh[7:0]};
      3'd5: ld_data = {16'b0, ld_sh[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      st_q           <= 1'b0;
      f3_q           <= 3'd0;
      off_q          <= 2'd0;
      web_q          <= 4'hF;
      cnt            <= '0;
      drop           <= 1'b0;
      DM_A           <= '0;
      DM_DI          <= '0;
      rsp_rdata      <= '0;
      rsp_rd         <= '0;
      rsp_fault      <= 1'b0;
      rsp_fault_code <= 2'b00;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          st_q           <= is_st;
          f3_q           <= f3;
          off_q          <= req_addr[1:0];
          web_q          <= web_n;
          DM_A           <= req_addr[DM_AW+1:2];
          DM_DI          <= di_n;
          rsp_rd         <= req_rd;
          rsp_rdata      <= '0;
          rsp_fault      <= 1'b0;
          rsp_fault_code <= 2'b00;
          drop           <= 1'b0;
          cnt            <= '0;
          if (illegal) begin
            state          <= RESP;
            rsp_fault      <= 1'b1;
            rsp_fault_code <= 2'b11;
          end else if (misal) begin
            state          <= RESP;
            rsp_fault      <= 1'b1;
            rsp_fault_code <= 2'b01;
          end else begin
            state <= REQ;
          end
        end
        REQ: begin
          if (dm_gnt) begin
            cnt <= '0;
            if (st_q) state <= RESP;
            else begin
              state <= WAIT;
              drop  <= flush;
            end
          end else if (flush) begin
            state <= IDLE;
          end else if (timeout) begin
            state          <= RESP;
            rsp_fault      <= 1'b1;
            rsp_fault_code <= 2'b10;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (flush) drop <= 1'b1;
          if (dm_rvalid) begin
            if (drop || flush) state <= IDLE;
            else begin
              state     <= RESP;
              rsp_rdata <= ld_data;
            end
          end else if (timeout) begin
            if (drop || flush) state <= IDLE;
            else begin
              state          <= RESP;
              rsp_fault      <= 1'b1;
              rsp_fault_code <= 2'b10;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign DM_CS     = (state == REQ);
  assign DM_OE     = (state == REQ && !st_q) || (state == WAIT);
  assign DM_WEB    = (state == REQ && st_q) ? web_q : 4'hF;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, load extension, faults,
// timeouts, flush and asynchronous reset.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        flush;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_fault;
  logic [1:0]  rsp_fault_code;
  logic        busy;
  logic        DM_CS;
  logic        DM_OE;
  logic [3:0]  DM_WEB;
  logic [13:0] DM_A;
  logic [31:0] DM_DI;
  logic [31:0] DM_DO;
  logic        dm_gnt;
  logic        dm_rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.DM_AW(14), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
    .rsp_fault(rsp_fault), .rsp_fault_code(rsp_fault_code), .busy(busy),
    .DM_CS(DM_CS), .DM_OE(DM_OE), .DM_WEB(DM_WEB), .DM_A(DM_A), .DM_DI(DM_DI),
    .DM_DO(DM_DO), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one access in an IDLE cycle, then scramble the request bus.
  task automatic accept(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
    chk("acc_ready", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rd = rd;
    tick();
    req_valid = 1'b0; req_op = 4'h0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_rd = 5'd0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [13:0] ea,
                          input logic [3:0] eweb, input logic [31:0] edi);
    accept({1'b1, f3}, addr, wd, 5'd0);
    chk({tag, "_cs"}, DM_CS, 1);
    chk({tag, "_oe"}, DM_OE, 0);
    chk({tag, "_a"}, DM_A, ea);
    chk({tag, "_web"}, DM_WEB, eweb);
    chk({tag, "_di"}, DM_DI, edi);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk({tag, "_rsp"}, rsp_valid, 1);
    chk({tag, "_flt"}, rsp_fault, 0);
    chk({tag, "_cs2"}, DM_CS, 0);
    chk({tag, "_web2"}, DM_WEB, 4'hF);
    tick();
    chk({tag, "_idle"}, rsp_valid, 0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] exp);
    accept({1'b0, f3}, addr, 32'h0, rd);
    chk({tag, "_cs"}, DM_CS, 1);
    chk({tag, "_oe"}, DM_OE, 1);
    chk({tag, "_web"}, DM_WEB, 4'hF);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk({tag, "_wcs"}, DM_CS, 0);
    chk({tag, "_woe"}, DM_OE, 1);
    tick();
    chk({tag, "_norsp"}, rsp_valid, 0);
    dm_rvalid = 1'b1; DM_DO = 32'h80FF_0000;
    tick();
    dm_rvalid = 1'b0; DM_DO = 32'h0;
    chk({tag, "_rsp"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_rdata, exp);
    chk({tag, "_rd"}, rsp_rd, rd);
    chk({tag, "_flt"}, rsp_fault, 0);
    tick();
    chk({tag, "_idle"}, req_ready, 1);
  endtask

  task automatic do_fault(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [1:0] code);
    accept(op, addr, 32'h1234_5678, 5'd3);
    chk({tag, "_rsp"}, rsp_valid, 1);
    chk({tag, "_flt"}, rsp_fault, 1);
    chk({tag, "_code"}, rsp_fault_code, code);
    chk({tag, "_data"}, rsp_rdata, 0);
    chk({tag, "_cs"}, DM_CS, 0);
    chk({tag, "_ready"}, req_ready, 0);
    tick();
    chk({tag, "_idle"}, req_ready, 1);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
    req_rd = 5'd0; flush = 1'b0; DM_DO = 32'h0; dm_gnt = 1'b0; dm_rvalid = 1'b0;
    tick(); tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_rd", rsp_rd, 0);
    chk("rst_fault", {rsp_fault, rsp_fault_code}, 0);
    chk("rst_cs", DM_CS, 0);
    chk("rst_oe", DM_OE, 0);
    chk("rst_web", DM_WEB, 4'hF);
    chk("rst_a", DM_A, 0);
    chk("rst_di", DM_DI, 0);
    rst = 1'b1;
    tick();

    do_store("sw", 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 14'h041, 4'b0000, 32'hDEAD_BEEF);
    do_store("sb", 3'd0, 32'h0000_0107, 32'h0000_00A5, 14'h041, 4'b0111, 32'hA500_0000);
    do_store("sh", 3'd1, 32'h0000_0102, 32'h0000_1234, 14'h040, 4'b0011, 32'h1234_0000);
    do_store("sb0", 3'd0, 32'h0000_0200, 32'hFFFF_FF3C, 14'h080, 4'b1110, 32'h0000_003C);

    do_load("lb", 3'd0, 32'h0000_0203, 5'd5, 32'hFFFF_FF80);
    do_load("lbu", 3'd4, 32'h0000_0203, 5'd6, 32'h0000_0080);
    do_load("lh", 3'd1, 32'h0000_0202, 5'd7, 32'hFFFF_80FF);
    do_load("lhu", 3'd5, 32'h0000_0202, 5'd31, 32'h0000_80FF);
    do_load("lw", 3'd2, 32'h0000_0200, 5'd1, 32'h80FF_0000);
    do_load("lbu2", 3'd4, 32'h0000_0202, 5'd2, 32'h0000_00FF);

    do_fault("lw_mis", 4'b0010, 32'h0000_0206, 2'b01);
    do_fault("lh_mis", 4'b0001, 32'h0000_0201, 2'b01);
    do_fault("st_ill", 4'b1011, 32'h0000_0200, 2'b11);
    do_fault("ld_ill", 4'b0110, 32'h0000_0200, 2'b11);

    // Timeout while the grant never comes: 8 REQ cycles, response at k+9.
    accept(4'b1010, 32'h0000_0300, 32'h5555_AAAA, 5'd0);
    for (int i = 0; i < 8; i++) begin
      chk("to_req_cs", DM_CS, 1);
      tick();
    end
    chk("to_req_rsp", rsp_valid, 1);
    chk("to_req_code", {rsp_fault, rsp_fault_code}, 3'b110);
    chk("to_req_data", rsp_rdata, 0);
    chk("to_req_cs_off", DM_CS, 0);
    tick();

    // Timeout while waiting for read data: response 8 cycles after WAIT entry.
    accept(4'b0010, 32'h0000_0300, 32'h0, 5'd4);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_wait_norsp", rsp_valid, 0);
      tick();
    end
    chk("to_wait_rsp", rsp_valid, 1);
    chk("to_wait_code", {rsp_fault, rsp_fault_code}, 3'b110);
    tick();

    // Flush during WAIT: read data still drains, but no response is given.
    accept(4'b0010, 32'h0000_0200, 32'h0, 5'd9);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fw_busy1", busy, 1);
    tick();
    chk("fw_norsp", rsp_valid, 0);
    tick();
    dm_rvalid = 1'b1; DM_DO = 32'h1111_2222;
    chk("fw_busy2", busy, 1);
    tick();
    dm_rvalid = 1'b0; DM_DO = 32'h0;
    chk("fw_rsp", rsp_valid, 0);
    chk("fw_ready", req_ready, 1);
    do_load("post_flush", 3'd2, 32'h0000_0200, 5'd10, 32'h80FF_0000);

    // Flush during REQ with no grant: straight back to IDLE.
    accept(4'b0010, 32'h0000_0200, 32'h0, 5'd11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fr_ready", req_ready, 1);
    chk("fr_rsp", rsp_valid, 0);
    chk("fr_cs", DM_CS, 0);

    // Asynchronous reset while a store is requesting.
    accept(4'b1010, 32'h0000_0104, 32'hCAFE_F00D, 5'd0);
    chk("ar_cs_pre", DM_CS, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_cs", DM_CS, 0);
    chk("ar_web", DM_WEB, 4'hF);
    chk("ar_busy", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_ready", req_ready, 1);
    chk("ar_rsp", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
